// File: rtl/greenhouse_pkg.sv
// Shared types for the greenhouse time-of-day scheduler: minute-of-day
// representation, schedule table entry layout and scheduler FSM states.
package greenhouse_pkg;

  localparam int MIN_PER_DAY = 1440;

  // Minute of the day, 0..1439.
  typedef logic [10:0] tod_t;

  // Channel field is sized for the largest supported channel count (8);
  // narrower builds only use the low bits.
  typedef struct packed {
    logic        enable;
    logic [2:0]  channel;
    tod_t        start;
    logic [10:0] duration;
  } sched_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_COMMIT
  } sched_state_t;

  // Convert hh:mm into a minute-of-day value.
  function automatic tod_t to_tod(input logic [4:0] hh, input logic [5:0] mm);
    return tod_t'(hh) * tod_t'(60) + tod_t'(mm);
  endfunction

endpackage

// File: rtl/sched_window_check.sv
// Combinational on-window test for one schedule entry against the current
// minute of day. Windows wrap past midnight; durations of a full day or more
// keep the entry permanently active.
module sched_window_check
  import greenhouse_pkg::*;
(
  input  tod_t        now,
  input  logic        enable,
  input  tod_t        start,
  input  logic [10:0] duration,
  output logic        hit
);

  // Durations beyond one day are equivalent to exactly one day.
  function automatic logic signed [12:0] sat_duration(input logic [10:0] dur);
    if (dur > 11'(MIN_PER_DAY)) return 13'sd1440;
    else return signed'({2'b00, dur});
  endfunction

  logic signed [12:0] delta;

  // Elapsed minutes since the window start, folded into 0..1439, then compared.
  always_comb begin
    delta = signed'({2'b00, now}) - signed'({2'b00, start});
    if (delta < 13'sd0) delta = delta + 13'sd1440;
    hit = enable && (delta < sat_duration(duration));
  end

endmodule

// File: rtl/irrigation_scheduler.sv
// Time-of-day actuator scheduler. Holds NUM_ENTRIES programmable on-windows
// and rescans them one entry per cycle whenever the minute changes or the
// table is written; the ORed result per channel is committed to chan_on.
// Optional feature macro: MANUAL_OVERRIDE_EN adds ovr_mask/ovr_value inputs
// that force individual channels combinationally over the schedule.
module irrigation_scheduler
  import greenhouse_pkg::*;
#(
  parameter int NUM_ENTRIES  = 8,
  parameter int NUM_CHANNELS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [5:0]                      seconds,
  input  logic [5:0]                      minutes,
  input  logic [4:0]                      hours,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [$clog2(NUM_ENTRIES)-1:0]  cfg_index,
  input  logic                            cfg_enable,
  input  logic [$clog2(NUM_CHANNELS)-1:0] cfg_channel,
  input  logic [4:0]                      cfg_start_hour,
  input  logic [5:0]                      cfg_start_min,
  input  logic [10:0]                     cfg_duration,
`ifdef MANUAL_OVERRIDE_EN
  input  logic [NUM_CHANNELS-1:0]         ovr_mask,
  input  logic [NUM_CHANNELS-1:0]         ovr_value,
`endif
  output logic [NUM_CHANNELS-1:0]         chan_on,
  output logic                            busy
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CH_W  = $clog2(NUM_CHANNELS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  sched_entry_t              entries [NUM_ENTRIES];
  sched_entry_t              cur;
  sched_entry_t              wr_entry;
  sched_state_t              state, state_n;
  logic [5:0]                prev_min;
  logic                      pending, pending_n;
  logic                      cfg_ready_q;
  logic [IDX_W-1:0]          idx;
  logic [NUM_CHANNELS-1:0]   acc;
  logic [NUM_CHANNELS-1:0]   sched;
  logic [CH_W-1:0]           cur_ch;
  tod_t                      now;
  logic                      cur_hit;
  logic                      min_change;
  logic                      cfg_accept;
  logic                      unused_bits;

  assign now         = to_tod(hours, minutes);
  assign cur         = entries[idx];
  assign cur_ch      = cur.channel[CH_W-1:0];
  assign min_change  = (minutes != prev_min);
  assign cfg_ready   = cfg_ready_q;
  assign cfg_accept  = cfg_valid && cfg_ready_q;
  assign busy        = (state == ST_SCAN) || (state == ST_COMMIT);
  assign unused_bits = ^{seconds, cur.channel};

  sched_window_check u_window (
    .now      (now),
    .enable   (cur.enable),
    .start    (cur.start),
    .duration (cur.duration),
    .hit      (cur_hit)
  );

  // Build the entry image for a config write; out-of-range start times are stored disabled.
  always_comb begin
    wr_entry                    = '0;
    wr_entry.channel[CH_W-1:0]  = cfg_channel;
    wr_entry.start              = to_tod(cfg_start_hour, cfg_start_min);
    wr_entry.duration           = cfg_duration;
    wr_entry.enable             = cfg_enable && (cfg_start_hour <= 5'd23) &&
                                  (cfg_start_min <= 6'd59);
  end

  // Next-state logic; a minute change while starting a scan re-arms pending.
  always_comb begin
    state_n   = state;
    pending_n = pending || min_change || cfg_accept;
    case (state)
      ST_IDLE: begin
        if (pending) begin
          state_n   = ST_SCAN;
          pending_n = min_change;
        end
      end
      ST_SCAN:   if (idx == LAST_IDX) state_n = ST_COMMIT;
      ST_COMMIT: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Trigger tracking and registered handshake ready (ready is high out of reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= 1'b1;
      prev_min    <= '0;
      cfg_ready_q <= 1'b1;
    end else begin
      pending     <= pending_n;
      prev_min    <= minutes;
      cfg_ready_q <= (state_n == ST_IDLE) && !pending_n;
    end
  end

  // Scan walker: one entry per cycle into acc, committed to sched at the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      acc   <= '0;
      sched <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pending) begin
            idx <= '0;
            acc <= '0;
          end
        end
        ST_SCAN: begin
          if (cur_hit) acc[cur_ch] <= 1'b1;
          idx <= idx + 1'b1;
        end
        ST_COMMIT: sched <= acc;
        default: ;
      endcase
    end
  end

  // Schedule table storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entries[i] <= '0;
    end else if (cfg_accept) begin
      entries[cfg_index] <= wr_entry;
    end
  end

`ifdef MANUAL_OVERRIDE_EN
  assign chan_on = (ovr_mask & ovr_value) | (~ovr_mask & sched);
`else
  assign chan_on = sched;
`endif

endmodule
